// File: rtl/nibble_serial_adder_ctrl.sv
// Digit-serial unsigned adder: one 4-bit ripple stage reused over NIBBLES cycles, LSD first.
// Define NSA_OVERFLOW_FLAG_EN to add the registered signed-overflow output OVF.
module nibble_serial_adder_ctrl #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   START,
    input  logic [4*NIBBLES-1:0]   A,
    input  logic [4*NIBBLES-1:0]   B,
    input  logic                   C_in,
    output logic [4*NIBBLES-1:0]   SUM,
    output logic                   C_out,
    output logic                   BUSY,
    output logic                   DONE
`ifdef NSA_OVERFLOW_FLAG_EN
    ,
    output logic                   OVF
`endif
);

    localparam int unsigned W    = 4 * NIBBLES;
    localparam int unsigned IdxW = $clog2(NIBBLES);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFin
    } state_e;

    state_e          state_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    sum_q;
    logic [IdxW-1:0] idx_q;
    logic            carry_q;
    logic            cout_q;
    logic            busy_q;
    logic            done_q;

    logic [3:0]      a_dig;
    logic [3:0]      b_dig;
    logic [3:0]      low_sum;
    logic [1:0]      top_sum;
    logic [3:0]      dig_sum;
    logic            dig_carry;

    // Split the digit add at bit 3 so the carry into the MSB is visible for overflow.
    always_comb begin
        a_dig     = a_q[{idx_q, 2'b00} +: 4];
        b_dig     = b_q[{idx_q, 2'b00} +: 4];
        low_sum   = {1'b0, a_dig[2:0]} + {1'b0, b_dig[2:0]} + {3'b000, carry_q};
        top_sum   = {1'b0, a_dig[3]} + {1'b0, b_dig[3]} + {1'b0, low_sum[3]};
        dig_sum   = {top_sum[0], low_sum[2:0]};
        dig_carry = top_sum[1];
    end

`ifdef NSA_OVERFLOW_FLAG_EN
    logic ovf_q;
    logic dig_ovf;

    always_comb begin
        dig_ovf = low_sum[3] ^ top_sum[1];
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ovf_q <= 1'b0;
        end else if (state_q == StIdle && START) begin
            ovf_q <= 1'b0;
        end else if (state_q == StRun && idx_q == LastIdx) begin
            ovf_q <= dig_ovf;
        end
    end

    assign OVF = ovf_q;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // Status flags trail the state by one edge so DONE lands after FIN.
            busy_q <= (state_q != StIdle);
            done_q <= (state_q == StFin);
            unique case (state_q)
                StIdle: begin
                    if (START) begin
                        a_q     <= A;
                        b_q     <= B;
                        carry_q <= C_in;
                        sum_q   <= '0;
                        cout_q  <= 1'b0;
                        idx_q   <= '0;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    sum_q[{idx_q, 2'b00} +: 4] <= dig_sum;
                    carry_q                    <= dig_carry;
                    if (idx_q == LastIdx) begin
                        cout_q  <= dig_carry;
                        idx_q   <= '0;
                        state_q <= StFin;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                StFin: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign SUM   = sum_q;
    assign C_out = cout_q;
    assign BUSY  = busy_q;
    assign DONE  = done_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for nibble_serial_adder_ctrl (NIBBLES=4): vector table plus corner sequences.
module tb_nibble_serial_adder_ctrl;

    localparam int W = 16;

    logic         CLK = 1'b0;
    logic         RST;
    logic         START;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         C_in;
    logic [W-1:0] SUM;
    logic         C_out;
    logic         BUSY;
    logic         DONE;
`ifdef NSA_OVERFLOW_FLAG_EN
    logic         OVF;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    vec_t vecs[10];

    nibble_serial_adder_ctrl #(
        .NIBBLES(4)
    ) dut (
        .CLK  (CLK),
        .RST  (RST),
        .START(START),
        .A    (A),
        .B    (B),
        .C_in (C_in),
        .SUM  (SUM),
        .C_out(C_out),
        .BUSY (BUSY),
        .DONE (DONE)
`ifdef NSA_OVERFLOW_FLAG_EN
        ,
        .OVF  (OVF)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic chk_result(input string tag, input vec_t v);
        chk({tag, " sum"}, 64'(SUM), 64'(v.sum));
        chk({tag, " cout"}, 64'(C_out), 64'(v.cout));
`ifdef NSA_OVERFLOW_FLAG_EN
        chk({tag, " ovf"}, 64'(OVF), 64'(v.ovf));
`endif
    endtask

    // Leaves the bench at the negedge of cycle 0 (just after the accepting edge).
    task automatic apply_start(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        @(negedge CLK);
        A     = a;
        B     = b;
        C_in  = cin;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        apply_start(v.a, v.b, v.cin);
        chk({tag, " busy c0"}, 64'(BUSY), 64'd0);
        for (int k = 1; k <= 7; k++) begin
            @(negedge CLK);
            chk($sformatf("%s busy c%0d", tag, k), 64'(BUSY), (k <= 5) ? 64'd1 : 64'd0);
            chk($sformatf("%s done c%0d", tag, k), 64'(DONE), (k == 5) ? 64'd1 : 64'd0);
            if (k == 5) chk_result(tag, v);
        end
    endtask

    initial begin
        vec_t v;
        int   ndone;

        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
        vecs[2] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[4] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[5] = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0};
        vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[7] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
        vecs[8] = '{16'h0999, 16'h0001, 1'b0, 16'h099A, 1'b0, 1'b0};
        vecs[9] = '{16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0, 1'b0};

        RST   = 1'b1;
        START = 1'b0;
        A     = '0;
        B     = '0;
        C_in  = 1'b0;
        repeat (2) @(negedge CLK);
        v = '{16'h0, 16'h0, 1'b0, 16'h0000, 1'b0, 1'b0};
        chk_result("reset", v);
        chk("reset busy", 64'(BUSY), 64'd0);
        chk("reset done", 64'(DONE), 64'd0);
        RST = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Operands change right after acceptance; a START during RUN is ignored.
        @(negedge CLK);
        A     = 16'h1234;
        B     = 16'h4321;
        C_in  = 1'b1;
        START = 1'b1;
        @(posedge CLK);
        #1;
        A     = 16'hAAAA;
        B     = 16'hAAAA;
        C_in  = 1'b0;
        START = 1'b0;
        v = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
        for (int k = 0; k <= 12; k++) begin
            @(negedge CLK);
            chk($sformatf("isolate done c%0d", k), 64'(DONE), (k == 5) ? 64'd1 : 64'd0);
            if (k == 2) START = 1'b1;
            if (k == 3) START = 1'b0;
            if (k == 5) chk_result("isolate", v);
        end
        chk("hold sum", 64'(SUM), 64'h5556);
        chk("hold cout", 64'(C_out), 64'd0);

        // START held high for ten edges: back-to-back operations.
        @(negedge CLK);
        A     = 16'h0F0F;
        B     = 16'h00F1;
        C_in  = 1'b0;
        START = 1'b1;
        ndone = 0;
        for (int k = 0; k <= 16; k++) begin
            @(negedge CLK);
            if (k == 9) START = 1'b0;
            if (DONE) begin
                ndone++;
                chk($sformatf("held done%0d cycle", ndone), 64'(k), (ndone == 1) ? 64'd5 : 64'd11);
                chk($sformatf("held sum%0d", ndone), 64'(SUM), 64'h1000);
                chk($sformatf("held cout%0d", ndone), 64'(C_out), 64'd0);
            end
        end
        chk("held done count", 64'(ndone), 64'd2);

        // Reset during cycle 3 aborts the operation.
        apply_start(16'h8000, 16'h8000, 1'b0);
        repeat (3) @(negedge CLK);
        chk("abort busy before", 64'(BUSY), 64'd1);
        RST = 1'b1;
        #1;
        v = '{16'h0, 16'h0, 1'b0, 16'h0000, 1'b0, 1'b0};
        chk_result("abort", v);
        chk("abort busy", 64'(BUSY), 64'd0);
        chk("abort done", 64'(DONE), 64'd0);
        @(negedge CLK);
        RST   = 1'b0;
        ndone = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK);
            if (DONE) ndone++;
        end
        chk("abort no done", 64'(ndone), 64'd0);
        run_vec(vecs[3], "after_abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
